// File: rtl/calc_operand_sequencer.sv
// Operand/op collector and Confirm-pulse sequencer in front of the calculator core.
// Optional button debounce is compiled in with `define CALC_SEQ_DEBOUNCE_EN.
module calc_operand_sequencer #(
    parameter int DEB_CYCLES     = 16,
    parameter int CONFIRM_GAP    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Sw,
    input  logic        Btn,
    input  logic        Done,
    input  logic [15:0] C,
    input  logic        Flag,
    output logic [15:0] Ain,
    output logic [15:0] Bin,
    output logic [1:0]  Op,
    output logic        Confirm,
    output logic [15:0] Result,
    output logic        ResultValid,
    output logic        Ovf,
    output logic        TimeoutErr,
    output logic        Busy
);

    localparam int GAP_W = (CONFIRM_GAP > 0) ? $clog2(CONFIRM_GAP + 1) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_OP,
        S_ISSUE,
        S_WAIT_DONE,
        S_SHOW,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              level_prev_q, level_prev_d;
    logic              btn_level;
    logic              press;
    logic [15:0]       ain_q, ain_d;
    logic [15:0]       bin_q, bin_d;
    logic [1:0]        op_q, op_d;
    logic [15:0]       result_q, result_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              terr_q, terr_d;
    logic              ack_q, ack_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [1:0]        pulse_q, pulse_d;
    logic [TO_W-1:0]   to_q, to_d;

`ifdef CALC_SEQ_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic              deb_level_q, deb_level_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;

    // Accept the synchronized level only after it differs from the accepted one for DEB_CYCLES cycles.
    always_comb begin
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        if (sync2_q != deb_level_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                deb_level_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
        end else begin
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
        end
    end

    assign btn_level = deb_level_q;
`else
    assign btn_level = sync2_q;
`endif

    assign press = btn_level & ~level_prev_q;

    always_comb begin
        sync1_d      = Btn;
        sync2_d      = sync1_q;
        level_prev_d = btn_level;
        state_d      = state_q;
        ain_d        = ain_q;
        bin_d        = bin_q;
        op_d         = op_q;
        result_d     = result_q;
        valid_d      = valid_q;
        ovf_d        = ovf_q;
        terr_d       = terr_q;
        ack_d        = 1'b0;
        gap_d        = gap_q;
        pulse_d      = pulse_q;
        to_d         = to_q;

        case (state_q)
            S_IDLE: begin
                if (press) begin
                    valid_d = 1'b0;
                    ovf_d   = 1'b0;
                    terr_d  = 1'b0;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (press) begin
                    ain_d   = Sw;
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (press) begin
                    bin_d   = Sw;
                    state_d = S_LOAD_OP;
                end
            end
            S_LOAD_OP: begin
                if (press) begin
                    op_d    = Sw[1:0];
                    gap_d   = '0;
                    pulse_d = '0;
                    state_d = S_ISSUE;
                end
            end
            // A pulse goes out whenever the gap counter is 0; the 4th pulse hands over to WAIT_DONE.
            S_ISSUE: begin
                gap_d = (gap_q == GAP_W'(CONFIRM_GAP)) ? '0 : gap_q + 1'b1;
                if (gap_q == '0) begin
                    if (pulse_q == 2'd3) begin
                        to_d    = '0;
                        state_d = S_WAIT_DONE;
                    end else begin
                        pulse_d = pulse_q + 2'd1;
                    end
                end
            end
            // Done is checked before the timeout so a simultaneous Done still captures.
            S_WAIT_DONE: begin
                if (Done) begin
                    result_d = C;
                    ovf_d    = Flag;
                    valid_d  = 1'b1;
                    state_d  = S_SHOW;
                end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_ERR;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_SHOW: begin
                if (press) begin
                    ack_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (press) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_prev_q <= 1'b0;
            ain_q        <= '0;
            bin_q        <= '0;
            op_q         <= '0;
            result_q     <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
            terr_q       <= 1'b0;
            ack_q        <= 1'b0;
            gap_q        <= '0;
            pulse_q      <= '0;
            to_q         <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_prev_q <= level_prev_d;
            ain_q        <= ain_d;
            bin_q        <= bin_d;
            op_q         <= op_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
            terr_q       <= terr_d;
            ack_q        <= ack_d;
            gap_q        <= gap_d;
            pulse_q      <= pulse_d;
            to_q         <= to_d;
        end
    end

    // Confirm is decoded from flops only, so asserting Reset removes it without waiting for a clock.
    assign Confirm     = ((state_q == S_ISSUE) && (gap_q == '0)) || ack_q;
    assign Busy        = (state_q == S_ISSUE) || (state_q == S_WAIT_DONE);
    assign Ain         = ain_q;
    assign Bin         = bin_q;
    assign Op          = op_q;
    assign Result      = result_q;
    assign ResultValid = valid_q;
    assign Ovf         = ovf_q;
    assign TimeoutErr  = terr_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed bench for calc_operand_sequencer: reset, add/overflow/timeout flows, discarded presses, abort.
// Honours CALC_SEQ_DEBOUNCE_EN for press latency and the debounce scenario.
module tb_calc_operand_sequencer;

`ifdef CALC_SEQ_DEBOUNCE_EN
    localparam int PRESS_LAT = 2 + 16;
`else
    localparam int PRESS_LAT = 2;
`endif
    localparam int HOLD  = PRESS_LAT + 4;
    localparam int TRACE = 80;

    logic        Clk;
    logic        Reset;
    logic [15:0] Sw;
    logic        Btn;
    logic        Done;
    logic [15:0] C;
    logic        Flag;
    logic [15:0] Ain;
    logic [15:0] Bin;
    logic [1:0]  Op;
    logic        Confirm;
    logic [15:0] Result;
    logic        ResultValid;
    logic        Ovf;
    logic        TimeoutErr;
    logic        Busy;

    int checks;
    int failures;
    int op_lat;
    int conf_total;
    int first_at;
    int press_total;
    logic conf_tr  [TRACE];
    logic busy_tr  [TRACE];
    logic valid_tr [TRACE];
    logic terr_tr  [TRACE];

    calc_operand_sequencer #(
        .DEB_CYCLES(16),
        .CONFIRM_GAP(2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Sw(Sw),
        .Btn(Btn),
        .Done(Done),
        .C(C),
        .Flag(Flag),
        .Ain(Ain),
        .Bin(Bin),
        .Op(Op),
        .Confirm(Confirm),
        .Result(Result),
        .ResultValid(ResultValid),
        .Ovf(Ovf),
        .TimeoutErr(TimeoutErr),
        .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(negedge Clk);
    endtask

    // Hold the button long enough to be accepted, then release long enough to settle; tally Confirms.
    task automatic do_press();
        first_at    = -1;
        press_total = 0;
        Btn = 1'b1;
        for (int k = 1; k <= 2 * HOLD; k++) begin
            step();
            if (Confirm === 1'b1) begin
                press_total++;
                if (first_at < 0) first_at = k;
            end
            if (k == HOLD) Btn = 1'b0;
        end
    endtask

    // Press from LOAD_OP and record outputs for TRACE cycles starting at the first Confirm.
    task automatic run_op_press(input int done_at, input logic [15:0] c_val, input logic flag_val, input bit wiggle);
        int n;
        n = 0;
        Btn = 1'b1;
        do begin
            step();
            n++;
        end while (Confirm !== 1'b1 && n < 200);
        op_lat = (Confirm === 1'b1) ? n : -1;
        conf_total = 0;
        for (int k = 0; k < TRACE; k++) begin
            conf_tr[k]  = Confirm;
            busy_tr[k]  = Busy;
            valid_tr[k] = ResultValid;
            terr_tr[k]  = TimeoutErr;
            if (Confirm === 1'b1) conf_total++;
            if (k == done_at) begin
                Done = 1'b1;
                C    = c_val;
                Flag = flag_val;
            end
            if (wiggle && k < 14) Btn = k[1];
            else Btn = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Sw = 16'hFFFF; Btn = 1'b0; Done = 1'b0; C = 16'hFFFF; Flag = 1'b1;
        step();
        step();
        checks++; if (Ain !== 16'h0) begin failures++; $display("[TB] FAIL reset_ain: got %h expected 0000", Ain); end
        checks++; if (Bin !== 16'h0) begin failures++; $display("[TB] FAIL reset_bin: got %h expected 0000", Bin); end
        checks++; if (Op !== 2'b00) begin failures++; $display("[TB] FAIL reset_op: got %b expected 00", Op); end
        checks++; if (Confirm !== 1'b0) begin failures++; $display("[TB] FAIL reset_confirm: got %b expected 0", Confirm); end
        checks++; if (Result !== 16'h0) begin failures++; $display("[TB] FAIL reset_result: got %h expected 0000", Result); end
        checks++; if (ResultValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", ResultValid); end
        checks++; if (Ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf: got %b expected 0", Ovf); end
        checks++; if (TimeoutErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_terr: got %b expected 0", TimeoutErr); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", Busy); end
        Reset = 1'b1;
        C = 16'h0; Flag = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_load();
        do_press();
        Sw = 16'h1111;
        do_press();
        checks++; if (Ain !== 16'h1111) begin failures++; $display("[TB] FAIL midload_ain_latched: got %h expected 1111", Ain); end
        Reset = 1'b0;
        #1;
        checks++; if (Ain !== 16'h0) begin failures++; $display("[TB] FAIL midload_ain_async_clear: got %h expected 0000", Ain); end
        step();
        step();
        Reset = 1'b1;
        step();
        Sw = 16'hABCD;
        do_press();
        do_press();
        checks++; if (Ain !== 16'hABCD) begin failures++; $display("[TB] FAIL midload_reenter_ain: got %h expected abcd", Ain); end
        checks++; if (Bin !== 16'h0) begin failures++; $display("[TB] FAIL midload_reenter_bin: got %h expected 0000", Bin); end
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        step();
    endtask

    task automatic test_add();
        do_press();
        Sw = 16'h0012;
        do_press();
        Sw = 16'h0034;
        do_press();
        checks++; if (Ain !== 16'h0012) begin failures++; $display("[TB] FAIL add_ain: got %h expected 0012", Ain); end
        checks++; if (Bin !== 16'h0034) begin failures++; $display("[TB] FAIL add_bin: got %h expected 0034", Bin); end
        Sw = 16'h0000;
        run_op_press(12, 16'h0046, 1'b0, 1'b0);
        checks++; if (op_lat !== PRESS_LAT + 1) begin failures++; $display("[TB] FAIL add_issue_latency: got %0d expected %0d", op_lat, PRESS_LAT + 1); end
        for (int p = 0; p < 4; p++) begin
            checks++; if (conf_tr[p * 3] !== 1'b1) begin failures++; $display("[TB] FAIL add_pulse_%0d: got %b expected 1", p, conf_tr[p * 3]); end
        end
        checks++; if (conf_tr[1] !== 1'b0) begin failures++; $display("[TB] FAIL add_gap: got %b expected 0", conf_tr[1]); end
        checks++; if (conf_total !== 4) begin failures++; $display("[TB] FAIL add_pulse_count: got %0d expected 4", conf_total); end
        checks++; if (busy_tr[0] !== 1'b1) begin failures++; $display("[TB] FAIL add_busy_issue: got %b expected 1", busy_tr[0]); end
        checks++; if (valid_tr[12] !== 1'b0) begin failures++; $display("[TB] FAIL add_valid_before: got %b expected 0", valid_tr[12]); end
        checks++; if (valid_tr[13] !== 1'b1) begin failures++; $display("[TB] FAIL add_valid_after: got %b expected 1", valid_tr[13]); end
        checks++; if (busy_tr[13] !== 1'b0) begin failures++; $display("[TB] FAIL add_busy_show: got %b expected 0", busy_tr[13]); end
        checks++; if (Result !== 16'h0046) begin failures++; $display("[TB] FAIL add_result: got %h expected 0046", Result); end
        checks++; if (Ovf !== 1'b0) begin failures++; $display("[TB] FAIL add_ovf: got %b expected 0", Ovf); end
        checks++; if (Op !== 2'b00) begin failures++; $display("[TB] FAIL add_op: got %b expected 00", Op); end
        do_press();
        Done = 1'b0;
        checks++; if (first_at !== PRESS_LAT + 1) begin failures++; $display("[TB] FAIL add_ack_latency: got %0d expected %0d", first_at, PRESS_LAT + 1); end
        checks++; if (press_total !== 1) begin failures++; $display("[TB] FAIL add_ack_count: got %0d expected 1", press_total); end
        checks++; if (Result !== 16'h0046) begin failures++; $display("[TB] FAIL add_result_hold: got %h expected 0046", Result); end
        checks++; if (ResultValid !== 1'b1) begin failures++; $display("[TB] FAIL add_valid_hold: got %b expected 1", ResultValid); end
        do_press();
        checks++; if (ResultValid !== 1'b0) begin failures++; $display("[TB] FAIL add_valid_clear: got %b expected 0", ResultValid); end
        checks++; if (Ain !== 16'h0012) begin failures++; $display("[TB] FAIL add_ain_kept: got %h expected 0012", Ain); end
    endtask

    task automatic test_overflow();
        Sw = 16'h8000;
        do_press();
        Sw = 16'h0002;
        do_press();
        Sw = 16'h0002;
        run_op_press(11, 16'h0000, 1'b1, 1'b0);
        checks++; if (Result !== 16'h0000) begin failures++; $display("[TB] FAIL ovf_result: got %h expected 0000", Result); end
        checks++; if (Ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag: got %b expected 1", Ovf); end
        checks++; if (ResultValid !== 1'b1) begin failures++; $display("[TB] FAIL ovf_valid: got %b expected 1", ResultValid); end
        checks++; if (Op !== 2'b10) begin failures++; $display("[TB] FAIL ovf_op: got %b expected 10", Op); end
        checks++; if (Ain !== 16'h8000) begin failures++; $display("[TB] FAIL ovf_ain: got %h expected 8000", Ain); end
        do_press();
        Done = 1'b0;
        Flag = 1'b0;
        checks++; if (press_total !== 1) begin failures++; $display("[TB] FAIL ovf_ack_count: got %0d expected 1", press_total); end
        do_press();
        checks++; if (Ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear: got %b expected 0", Ovf); end
    endtask

    task automatic test_timeout();
        Sw = 16'h0005;
        do_press();
        Sw = 16'h0003;
        do_press();
        Sw = 16'h0001;
        Done = 1'b0;
        run_op_press(-1, 16'h0000, 1'b0, 1'b0);
        checks++; if (conf_total !== 4) begin failures++; $display("[TB] FAIL to_pulse_count: got %0d expected 4", conf_total); end
        checks++; if (terr_tr[73] !== 1'b0) begin failures++; $display("[TB] FAIL to_err_early: got %b expected 0", terr_tr[73]); end
        checks++; if (busy_tr[73] !== 1'b1) begin failures++; $display("[TB] FAIL to_busy_wait: got %b expected 1", busy_tr[73]); end
        checks++; if (terr_tr[74] !== 1'b1) begin failures++; $display("[TB] FAIL to_err_set: got %b expected 1", terr_tr[74]); end
        checks++; if (busy_tr[74] !== 1'b0) begin failures++; $display("[TB] FAIL to_busy_err: got %b expected 0", busy_tr[74]); end
        checks++; if (valid_tr[74] !== 1'b0) begin failures++; $display("[TB] FAIL to_valid: got %b expected 0", valid_tr[74]); end
        checks++; if (Op !== 2'b01) begin failures++; $display("[TB] FAIL to_op: got %b expected 01", Op); end
        do_press();
        checks++; if (press_total !== 0) begin failures++; $display("[TB] FAIL to_err_exit_confirm: got %0d expected 0", press_total); end
        checks++; if (TimeoutErr !== 1'b1) begin failures++; $display("[TB] FAIL to_err_hold: got %b expected 1", TimeoutErr); end
        do_press();
        checks++; if (TimeoutErr !== 1'b0) begin failures++; $display("[TB] FAIL to_err_clear: got %b expected 0", TimeoutErr); end
    endtask

    task automatic test_discard_and_abort();
        int n;
        int seen;
        Sw = 16'h0007;
        do_press();
        Sw = 16'h0009;
        do_press();
        Sw = 16'h0000;
        run_op_press(20, 16'h0010, 1'b0, 1'b1);
        checks++; if (conf_total !== 4) begin failures++; $display("[TB] FAIL discard_pulse_count: got %0d expected 4", conf_total); end
        checks++; if (conf_tr[9] !== 1'b1) begin failures++; $display("[TB] FAIL discard_pulse_4: got %b expected 1", conf_tr[9]); end
        checks++; if (busy_tr[20] !== 1'b1) begin failures++; $display("[TB] FAIL discard_still_waiting: got %b expected 1", busy_tr[20]); end
        checks++; if (valid_tr[21] !== 1'b1) begin failures++; $display("[TB] FAIL discard_capture: got %b expected 1", valid_tr[21]); end
        checks++; if (Result !== 16'h0010) begin failures++; $display("[TB] FAIL discard_result: got %h expected 0010", Result); end
        do_press();
        Done = 1'b0;
        checks++; if (press_total !== 1) begin failures++; $display("[TB] FAIL discard_ack_count: got %0d expected 1", press_total); end

        do_press();
        Sw = 16'h1234;
        do_press();
        Sw = 16'h5678;
        do_press();
        Sw = 16'h0003;
        n = 0;
        Btn = 1'b1;
        do begin
            step();
            n++;
        end while (Confirm !== 1'b1 && n < 200);
        repeat (6) step();
        checks++; if (Confirm !== 1'b1) begin failures++; $display("[TB] FAIL abort_pulse_3: got %b expected 1", Confirm); end
        Reset = 1'b0;
        Btn = 1'b0;
        #1;
        checks++; if (Confirm !== 1'b0) begin failures++; $display("[TB] FAIL abort_confirm_async: got %b expected 0", Confirm); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b expected 0", Busy); end
        checks++; if (Ain !== 16'h0) begin failures++; $display("[TB] FAIL abort_ain: got %h expected 0000", Ain); end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 3) Reset = 1'b1;
            if (Confirm === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL abort_no_confirm: got %0d expected 0", seen); end
        Sw = 16'h4242;
        do_press();
        do_press();
        checks++; if (Ain !== 16'h4242) begin failures++; $display("[TB] FAIL abort_idle_restart: got %h expected 4242", Ain); end
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        step();
    endtask

`ifdef CALC_SEQ_DEBOUNCE_EN
    task automatic test_debounce();
        int seen;
        int first;
        do_press();
        Sw = 16'h0001;
        do_press();
        Sw = 16'h0001;
        do_press();
        Sw = 16'h0000;
        run_op_press(12, 16'h0002, 1'b0, 1'b0);
        seen  = 0;
        first = -1;
        for (int k = 0; k < 100; k++) begin
            if (k < 60) Btn = ((k / 5) % 2 == 0);
            else Btn = 1'b1;
            step();
            if (Confirm === 1'b1) begin
                seen++;
                if (first < 0) first = k + 1;
            end
        end
        Btn = 1'b0;
        Done = 1'b0;
        repeat (HOLD) step();
        checks++; if (seen !== 1) begin failures++; $display("[TB] FAIL deb_press_count: got %0d expected 1", seen); end
        checks++; if (first !== 60 + PRESS_LAT + 1) begin failures++; $display("[TB] FAIL deb_press_time: got %0d expected %0d", first, 60 + PRESS_LAT + 1); end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_reset_mid_load();
        test_add();
        test_overflow();
        test_timeout();
        test_discard_and_abort();
`ifdef CALC_SEQ_DEBOUNCE_EN
        test_debounce();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
